// File: rtl/trap_unit.sv
// Commit-side trap sequencer: arbitrates exceptions, mret and machine interrupts,
// drains the data bus, pulses a CSR enter/leave update, then redirects fetch.
module trap_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit_valid,
    input  logic [63:0] commit_pc,
    input  logic [63:0] commit_next_pc,
    input  logic        commit_exc,
    input  logic [3:0]  commit_exc_code,
    input  logic [63:0] commit_tval,
    input  logic        commit_mret,
    input  logic        mtip,
    input  logic        msip,
    input  logic        meip,
    input  logic        csr_mstatus_mie,
    input  logic [63:0] csr_mie,
    input  logic [1:0]  csr_mode,
    input  logic [63:0] csr_mtvec,
    input  logic [63:0] csr_mepc,
    input  logic        mem_busy,
    output logic        enter,
    output logic        leave,
    output logic        interrupt,
    output logic [63:0] pc,
    output logic [62:0] code,
    output logic [63:0] value,
    output logic [63:0] mip,
    output logic        busy,
    output logic        flush,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc
);

    typedef enum logic [1:0] {IDLE, DRAIN, UPDATE, REDIRECT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cause_q;
    logic        intr_q, ret_q;
    logic [63:0] epc_q, tval_q;

    logic [63:0] irq_act;
    logic        irq_en;
    logic [3:0]  irq_cause;
    logic        take;
    logic [63:0] mtvec_base;

    assign irq_act = mip & csr_mie;
    assign irq_en  = (|irq_act) && (csr_mstatus_mie || (csr_mode != 2'b11));
    assign take    = (state == IDLE) && commit_valid && (commit_exc || irq_en || commit_mret);
    assign mtvec_base = {csr_mtvec[63:2], 2'b00};

    always_comb begin
        irq_cause = 4'd7;
        if (irq_act[11])
            irq_cause = 4'd11;
        else if (irq_act[3])
            irq_cause = 4'd3;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mip     <= '0;
            cause_q <= '0;
            intr_q  <= 1'b0;
            ret_q   <= 1'b0;
            epc_q   <= '0;
            tval_q  <= '0;
        end else begin
            state <= state_nxt;
            mip   <= '0;
            mip[11] <= meip;
            mip[7]  <= mtip;
            mip[3]  <= msip;
            // Exception beats interrupt beats mret.
            if (take) begin
                if (commit_exc) begin
                    cause_q <= commit_exc_code;
                    intr_q  <= 1'b0;
                    ret_q   <= 1'b0;
                    epc_q   <= commit_pc;
                    tval_q  <= commit_tval;
                end else if (irq_en) begin
                    cause_q <= irq_cause;
                    intr_q  <= 1'b1;
                    ret_q   <= 1'b0;
                    epc_q   <= commit_next_pc;
                    tval_q  <= '0;
                end else begin
                    ret_q   <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        enter          = 1'b0;
        leave          = 1'b0;
        interrupt      = 1'b0;
        pc             = '0;
        code           = '0;
        value          = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            IDLE:     if (take) state_nxt = DRAIN;
            DRAIN:    if (!mem_busy) state_nxt = UPDATE;
            UPDATE: begin
                state_nxt = REDIRECT;
                if (ret_q) begin
                    leave = 1'b1;
                end else begin
                    enter     = 1'b1;
                    interrupt = intr_q;
                    pc        = epc_q;
                    code      = {59'd0, cause_q};
                    value     = tval_q;
                end
            end
            REDIRECT: begin
                state_nxt      = IDLE;
                redirect_valid = 1'b1;
                if (ret_q)
                    redirect_pc = csr_mepc;
                else if (intr_q && (csr_mtvec[1:0] == 2'b01))
                    redirect_pc = mtvec_base + {58'd0, cause_q, 2'b00};
                else
                    redirect_pc = mtvec_base;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign flush = busy;

endmodule

// File: tb/tb_trap_unit.sv
// Scoreboard bench for trap_unit: expected updates queued at commit, checked on enter/leave/redirect.
module tb_trap_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        commit_valid = 1'b0;
    logic [63:0] commit_pc = '0, commit_next_pc = '0, commit_tval = '0;
    logic        commit_exc = 1'b0, commit_mret = 1'b0;
    logic [3:0]  commit_exc_code = '0;
    logic        mtip = 1'b0, msip = 1'b0, meip = 1'b0;
    logic        csr_mstatus_mie = 1'b0;
    logic [63:0] csr_mie = '0, csr_mtvec = '0, csr_mepc = '0;
    logic [1:0]  csr_mode = 2'b11;
    logic        mem_busy = 1'b0;
    logic        enter, leave, interrupt, busy, flush, redirect_valid;
    logic [63:0] pc, value, mip, redirect_pc;
    logic [62:0] code;

    trap_unit dut (
        .clk(clk), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_next_pc(commit_next_pc), .commit_exc(commit_exc), .commit_exc_code(commit_exc_code),
        .commit_tval(commit_tval), .commit_mret(commit_mret), .mtip(mtip), .msip(msip), .meip(meip),
        .csr_mstatus_mie(csr_mstatus_mie), .csr_mie(csr_mie), .csr_mode(csr_mode),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .mem_busy(mem_busy),
        .enter(enter), .leave(leave), .interrupt(interrupt), .pc(pc), .code(code), .value(value),
        .mip(mip), .busy(busy), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ret;
        logic        intr;
        logic [63:0] code;
        logic [63:0] pc;
        logic [63:0] value;
        logic [63:0] tgt;
        int          cyc;
    } exp_t;

    exp_t upd_q[$];
    exp_t red_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    endtask

    function automatic exp_t mk(input logic r, input logic i, input logic [63:0] c,
                                input logic [63:0] p, input logic [63:0] v, input logic [63:0] t);
        exp_t e;
        e.ret = r; e.intr = i; e.code = c; e.pc = p; e.value = v; e.tgt = t; e.cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (enter || leave) begin
            if (upd_q.size() == 0) begin
                chk("stray_update", 64'(enter || leave), 64'd0);
            end else begin
                e = upd_q.pop_front();
                chk("upd_cycle", 64'(cyc), 64'(e.cyc));
                chk("enter", 64'(enter), 64'(!e.ret));
                chk("leave", 64'(leave), 64'(e.ret));
                chk("interrupt", 64'(interrupt), 64'(e.intr));
                chk("code", {1'b0, code}, e.code);
                chk("pc", pc, e.pc);
                chk("value", value, e.value);
                chk("upd_flush", 64'(flush), 64'd1);
                chk("upd_no_redirect", 64'(redirect_valid), 64'd0);
                e.cyc = cyc + 1;
                red_q.push_back(e);
            end
        end
        if (redirect_valid) begin
            if (red_q.size() == 0) begin
                chk("stray_redirect", 64'(redirect_valid), 64'd0);
            end else begin
                e = red_q.pop_front();
                chk("redir_cycle", 64'(cyc), 64'(e.cyc));
                chk("redirect_pc", redirect_pc, e.tgt);
                chk("redir_flush", 64'(flush), 64'd1);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_flush", 64'(flush), 64'd0);
    endtask

    task automatic send(input logic exc, input logic [3:0] ec, input logic [63:0] cpc,
                        input logic [63:0] npc, input logic [63:0] tv, input logic mr,
                        input bit evt, input bit clr_irq, input exp_t e);
        @(posedge clk); #1;
        commit_valid = 1'b1; commit_exc = exc; commit_exc_code = ec;
        commit_pc = cpc; commit_next_pc = npc; commit_tval = tv; commit_mret = mr;
        if (evt) begin
            e.cyc = cyc + 2;
            upd_q.push_back(e);
        end
        @(posedge clk); #1;
        commit_valid = 1'b0; commit_exc = 1'b0; commit_mret = 1'b0;
        if (clr_irq) begin
            mtip = 1'b0; msip = 1'b0; meip = 1'b0;
        end
        @(negedge clk);
        chk("drain_busy", 64'(busy), 64'(evt));
        chk("drain_flush", 64'(flush), 64'(evt));
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        exp_t e;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_bundle", 64'(enter | leave | interrupt | redirect_valid | flush), 64'd0);
        chk("rst_mip", mip, 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Illegal instruction, direct mode
        csr_mtvec = 64'h8000_0100;
        send(1'b1, 4'd2, 64'h8000_0010, 64'h8000_0014, 64'hdead, 1'b0, 1'b1, 1'b0,
             mk(1'b0, 1'b0, 64'd2, 64'h8000_0010, 64'hdead, 64'h8000_0100));

        // Timer interrupt, vectored; line drops after the trap is latched
        csr_mstatus_mie = 1'b1; csr_mie = 64'h880; csr_mtvec = 64'h8000_0101;
        @(posedge clk); #1 mtip = 1'b1;
        @(negedge clk); #1 chk("mip_lag", mip, 64'h0);
        @(negedge clk); chk("mip_timer", mip, 64'h80);
        send(1'b0, 4'd0, 64'h8000_0020, 64'h8000_0024, 64'h55, 1'b0, 1'b1, 1'b1,
             mk(1'b0, 1'b1, 64'd7, 64'h8000_0024, 64'd0, 64'h8000_011c));

        // All three pending: MEI wins; then an exception beats them
        @(posedge clk); #1 begin meip = 1'b1; msip = 1'b1; mtip = 1'b1; csr_mie = 64'h888; end
        send(1'b0, 4'd0, 64'h8000_0030, 64'h8000_0034, 64'h0, 1'b0, 1'b1, 1'b0,
             mk(1'b0, 1'b1, 64'd11, 64'h8000_0034, 64'd0, 64'h8000_012c));
        chk("mip_all", mip, 64'h888);
        send(1'b1, 4'd8, 64'h8000_0030, 64'h8000_0034, 64'h77, 1'b0, 1'b1, 1'b0,
             mk(1'b0, 1'b0, 64'd8, 64'h8000_0030, 64'h77, 64'h8000_0100));

        // mret with an enabled interrupt: interrupt wins
        @(posedge clk); #1 begin meip = 1'b0; msip = 1'b0; end
        send(1'b0, 4'd0, 64'h8000_004c, 64'h8000_0050, 64'h0, 1'b1, 1'b1, 1'b1,
             mk(1'b0, 1'b1, 64'd7, 64'h8000_0050, 64'd0, 64'h8000_011c));

        // Plain mret
        csr_mepc = 64'h8000_0040;
        @(posedge clk);
        send(1'b0, 4'd0, 64'h8000_0060, 64'h8000_0064, 64'h0, 1'b1, 1'b1, 1'b0,
             mk(1'b1, 1'b0, 64'd0, 64'd0, 64'd0, 64'h8000_0040));

        // Drain: mem_busy for three DRAIN cycles, commit pulses while busy
        csr_mtvec = 64'h8000_0100;
        @(posedge clk); #1;
        commit_valid = 1'b1; commit_exc = 1'b1; commit_exc_code = 4'd5;
        commit_pc = 64'h8000_0070; commit_tval = 64'h1234; mem_busy = 1'b1;
        t = cyc;
        e = mk(1'b0, 1'b0, 64'd5, 64'h8000_0070, 64'h1234, 64'h8000_0100);
        e.cyc = t + 5;
        upd_q.push_back(e);
        @(posedge clk); #1;
        @(posedge clk); #1 commit_valid = 1'b0;
        @(posedge clk); #1 commit_valid = 1'b1;
        @(posedge clk); #1 begin mem_busy = 1'b0; commit_valid = 1'b0; commit_exc = 1'b0; end
        @(negedge clk); chk("drain_hold", 64'(busy), 64'd1);
        wait_idle();

        // Masked: M-mode with mstatus.mie=0
        csr_mstatus_mie = 1'b0; csr_mie = 64'h80; csr_mode = 2'b11;
        @(posedge clk); #1 mtip = 1'b1;
        send(1'b0, 4'd0, 64'h8000_0080, 64'h8000_0084, 64'h0, 1'b0, 1'b0, 1'b0,
             mk(1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0));
        // Lower privilege: enabled regardless of mstatus.mie
        csr_mode = 2'b00;
        send(1'b0, 4'd0, 64'h8000_0090, 64'h8000_0094, 64'h0, 1'b0, 1'b1, 1'b1,
             mk(1'b0, 1'b1, 64'd7, 64'h8000_0094, 64'd0, 64'h8000_0100));

        // Reset during UPDATE
        @(posedge clk); #1;
        commit_valid = 1'b1; commit_exc = 1'b1; commit_exc_code = 4'd4;
        commit_pc = 64'h8000_00a0; commit_tval = 64'h99;
        e = mk(1'b0, 1'b0, 64'd4, 64'h8000_00a0, 64'h99, 64'h8000_0100);
        e.cyc = cyc + 2;
        upd_q.push_back(e);
        @(posedge clk); #1 begin commit_valid = 1'b0; commit_exc = 1'b0; end
        @(negedge clk);
        @(negedge clk);
        chk("rstu_in_update", 64'(enter), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        red_q.delete();
        @(negedge clk);
        chk("rstu_busy", 64'(busy), 64'd0);
        chk("rstu_flags", 64'(enter | leave | interrupt | redirect_valid | flush), 64'd0);
        chk("rstu_data", pc | value | {1'b0, code} | redirect_pc, 64'd0);
        repeat (3) @(negedge clk);
        chk("rstu_quiet", 64'(busy | redirect_valid), 64'd0);

        chk("upd_q_empty", 64'(upd_q.size()), 64'd0);
        chk("red_q_empty", 64'(red_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
